serial_word_feeder: RTL and testbench
=====================================

# serial_word_feeder

Upstream stage for the serial sequence detectors. Accepts a parallel word over a valid/ready handshake and shifts it out one bit per clock on a single serial line, which drives the detector's `in` input. Supports back-to-back words with no idle bubble. Provides framing status: `out_valid`, `busy`, and a last-bit `done` pulse.

## Interface
- `WIDTH`, default 8: word length in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `IDLE_BIT`, default 0: level driven on `out` whenever no bit is being sent.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset. Asserted (0) forces all state to reset values immediately; deassertion takes effect at the next `clk` rising edge.
- `load_valid`  input  1  `load_data` holds a word to send.
- `load_data`  input  WIDTH  word to serialize; sampled only on handshake.
- `load_ready`  output  1  block can take a word this cycle.
- `out`  output  1  serial bit stream (registered).
- `out_valid`  output  1  `out` carries a data bit this cycle (registered).
- `busy`  output  1  a word is in flight (registered).
- `done`  output  1  high exactly during the cycle the last bit of a word is on `out` (registered).

## Operation
- Two states: IDLE and SHIFT. Internal registers:
  - WIDTH-bit shift register `sr`.
  - Bit counter `cnt` of $clog2(WIDTH) bits, counting 0..WIDTH-1.
- Handshake: a word is accepted on a rising edge where `load_valid && load_ready`. No acceptance is possible while `reset` is low.
- `load_ready` is combinational:
  - 1 in IDLE.
  - 1 in SHIFT when `cnt == WIDTH-1` (last bit on the line).
  - 0 otherwise, and 0 while `reset` is low.
- IDLE → SHIFT on accept:
  - `sr` loads `load_data`; `cnt` is set to 0.
  - `out` takes the first bit: `load_data[WIDTH-1]` if `MSB_FIRST`, else `load_data[0]`.
  - `out_valid` and `busy` become 1.
- SHIFT with `cnt < WIDTH-1`:
  - `sr` shifts toward the sent end; `cnt` increments.
  - `out` takes the next bit.
  - `done` becomes 1 on the edge where `cnt` becomes WIDTH-1.
- SHIFT with `cnt == WIDTH-1` and an accept on this edge (back-to-back):
  - Reload as for IDLE → SHIFT; `cnt` returns to 0.
  - `out_valid` and `busy` stay 1 with no gap.
  - `done` goes 0.
- SHIFT with `cnt == WIDTH-1` and no accept:
  - Go to IDLE.
  - `out` = `IDLE_BIT`; `out_valid`, `busy` and `done` all go 0.
- `load_data` changing while not accepted has no effect.
- `load_valid` held high during SHIFT (before the last bit) is ignored until `load_ready` rises; the word is not lost, because the upstream holds it per handshake.
- Reset mid-word: the in-flight word is discarded and is not resumed after reset.

## Timing
- Reset values, applied while `reset` = 0: state IDLE, `sr` = 0, `cnt` = 0, `out` = `IDLE_BIT`, `out_valid` = 0, `busy` = 0, `done` = 0, `load_ready` = 0.
- After reset deasserts: `load_ready` = 1.
- Latency: first bit appears on `out` one cycle after the accept edge. The last bit appears WIDTH cycles after the accept edge.
- `done` is asserted for exactly one cycle per word and coincides with the last data bit.
- Throughput: one word per WIDTH cycles when the upstream keeps `load_valid` high.
- All outputs except `load_ready` are registered and glitch-free.

## Test plan
- **Reset values.** Hold `reset` = 0 for 3 cycles, then release.
  - During reset: `out` = 0, `out_valid` = 0, `busy` = 0, `done` = 0, `load_ready` = 0.
  - First cycle after release: `load_ready` = 1.
- **Single word, MSB first.** WIDTH = 8, MSB_FIRST = 1, load 8'hA5 at edge 0.
  - `out` = 1,0,1,0,0,1,0,1 on cycles 1..8, with `out_valid` = 1 throughout.
  - `done` = 1 only in cycle 8.
  - Cycle 9: `out` = 0, `out_valid` = 0, `busy` = 0.
- **Back-to-back words.** 8'hA5 followed by 8'h3C, `load_valid` held high.
  - 8'h3C is accepted in cycle 8, when `load_ready` = 1.
  - Cycles 1..16 show 10100101 then 00111100 with no `out_valid` gap.
  - `done` = 1 in cycles 8 and 16.
- **Ignored load during SHIFT.** Raise `load_valid` with 8'hFF at cycle 3 of word 8'h00.
  - `load_ready` = 0 in cycles 1..7; the 8'h00 bits are unaffected.
  - 8'hFF is accepted in cycle 8; eight 1s appear in cycles 9..16.
- **LSB first.** MSB_FIRST = 0, load 8'h01.
  - `out` = 1 in cycle 1, then 0 in cycles 2..8.
- **Reset mid-word.** Load 8'hFF, drive `reset` = 0 asynchronously in cycle 4, release 2 cycles later.
  - `out` and `out_valid` drop to 0 immediately, without waiting for a clock edge.
  - No remaining bits of 8'hFF are emitted after release; `load_ready` = 1.

Source files
------------

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder: accepts a word on a valid/ready handshake and
// shifts it out one bit per clock, with back-to-back words and framing status.
module serial_word_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             dbg_state
);

  localparam int            CW      = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT  = CW'(WIDTH - 2);

  // Handshake: a word transfers on a rising clk edge where load_valid && load_ready.
  // load_ready is combinational and never asserts while reset is low.

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             last_bit;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] sr_adv;

  assign last_bit   = (state_q == S_SHIFT) && (cnt_q == LAST);
  assign load_ready = reset && ((state_q == S_IDLE) || last_bit);
  assign accept     = load_valid && load_ready;

  // The register rotates toward the sent end so the next bit to send always
  // sits next to the sent end; the wrapped bit is never read again.
  assign first_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign next_bit  = MSB_FIRST ? sr_q[WIDTH-2] : sr_q[1];
  assign sr_adv    = MSB_FIRST ? {sr_q[WIDTH-2:0], sr_q[WIDTH-1]}
                               : {sr_q[0], sr_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = done_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d     = S_SHIFT;
          sr_d        = load_data;
          cnt_d       = '0;
          out_d       = first_bit;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
        end
      end
      S_SHIFT: begin
        if (!last_bit) begin
          sr_d   = sr_adv;
          cnt_d  = cnt_q + CW'(1);
          out_d  = next_bit;
          done_d = (cnt_q == PENULT);
        end else if (accept) begin
          // Back-to-back reload: the line never idles between words.
          sr_d        = load_data;
          cnt_d       = '0;
          out_d       = first_bit;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
        end else begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          out_d       = IDLE_BIT;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      out_q       <= IDLE_BIT;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: an MSB-first and an LSB-first instance share the
// same stimulus and are compared every cycle against a bit-queue reference model.
module tb_serial_word_feeder;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] load_data;

  logic load_ready_m, out_m, out_valid_m, busy_m, done_m, dbg_state_m;
  logic load_ready_l, out_l, out_valid_l, busy_l, done_l, dbg_state_l;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic chk_en   = 1'b0;

  // Expected line contents: element 0 is the bit currently on out.
  logic exp_m_q[$];
  logic exp_l_q[$];

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready_m), .out(out_m), .out_valid(out_valid_m),
    .busy(busy_m), .done(done_m), .dbg_state(dbg_state_m)
  );

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready_l), .out(out_l), .out_valid(out_valid_l),
    .busy(busy_l), .done(done_l), .dbg_state(dbg_state_l)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_m_q.delete();
      exp_l_q.delete();
    end else begin
      logic acc;
      acc = load_valid && (exp_m_q.size() <= 1);
      if (exp_m_q.size() > 0) void'(exp_m_q.pop_front());
      if (exp_l_q.size() > 0) void'(exp_l_q.pop_front());
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          exp_m_q.push_back(load_data[W-1-i]);
          exp_l_q.push_back(load_data[i]);
        end
      end
    end
  end

  task automatic compare_inst(input string tag, input logic o, input logic ov,
                              input logic b, input logic d, input logic r,
                              input logic st, input int sz, input logic head,
                              input logic idle_bit);
    check({tag, "_out"},       {31'd0, o},  {31'd0, (sz > 0) ? head : idle_bit});
    check({tag, "_out_valid"}, {31'd0, ov}, {31'd0, sz > 0});
    check({tag, "_busy"},      {31'd0, b},  {31'd0, sz > 0});
    check({tag, "_done"},      {31'd0, d},  {31'd0, sz == 1});
    check({tag, "_ready"},     {31'd0, r},  {31'd0, reset && (sz <= 1)});
    check({tag, "_state"},     {31'd0, st}, {31'd0, sz > 0});
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      compare_inst("msb", out_m, out_valid_m, busy_m, done_m, load_ready_m, dbg_state_m,
                   exp_m_q.size(), (exp_m_q.size() > 0) ? exp_m_q[0] : 1'b0, 1'b0);
      compare_inst("lsb", out_l, out_valid_l, busy_l, done_l, load_ready_l, dbg_state_l,
                   exp_l_q.size(), (exp_l_q.size() > 0) ? exp_l_q[0] : 1'b0, 1'b1);
    end
  end

  // ---------------- drivers (entered/left at posedge + 1) ----------------
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    load_valid = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] d);
    logic got;
    got        = 1'b0;
    load_valid = 1'b1;
    load_data  = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (load_ready_m) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_drop();
    check("async_out_m",       {31'd0, out_m},        32'd0);
    check("async_out_valid_m", {31'd0, out_valid_m},  32'd0);
    check("async_out_l",       {31'd0, out_l},        32'd1);
    check("async_out_valid_l", {31'd0, out_valid_l},  32'd0);
    check("async_busy_m",      {31'd0, busy_m},       32'd0);
    check("async_ready_m",     {31'd0, load_ready_m}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(2);

    // Single word, then idle until it drains.
    send_word(8'hA5);
    idle();
    wait_cycles(10);

    // Back-to-back words with load_valid held high.
    send_word(8'hA5);
    send_word(8'h3C);
    idle();
    wait_cycles(10);

    // Load raised mid-word must wait for the last bit.
    send_word(8'h00);
    idle();
    wait_cycles(2);
    send_word(8'hFF);
    idle();
    wait_cycles(10);

    // LSB-first single-bit pattern.
    send_word(8'h01);
    idle();
    wait_cycles(10);

    // Asynchronous reset in the middle of a word.
    send_word(8'hFF);
    idle();
    wait_cycles(3);
    #2;
    reset = 1'b0;
    #1;
    check_reset_drop();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    wait_cycles(10);

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int i = 0; i < 600; i++) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = W'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        check_reset_drop();
        @(posedge clk);
        #1;
        reset = 1'b1;
      end else begin
        wait_cycles(1);
      end
    end
    idle();
    wait_cycles(12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
